// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types: prefix codes, frame FSM states, event record.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_fifo_basemod.sv
// First-word-fall-through FIFO of ps2_evt_t with count, full and sticky overflow.
module ps2_fifo_basemod
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          push_i,
    input  ps2_evt_t      din_i,
    input  logic          pop_i,
    output logic          valid_o,
    output ps2_evt_t      dout_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          ovf_o
);

    localparam int AW = $clog2(DEPTH);

    ps2_evt_t        mem_q [DEPTH];
    logic [AW-1:0]   rd_q, rd_d;
    logic [AW-1:0]   wr_q, wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            full, do_pop, do_push;

    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i && (cnt_q != '0);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (do_pop)
                rd_d = rd_q + AW'(1);
            if (do_push)
                wr_d = wr_q + AW'(1);
            if (do_push && !do_pop)
                cnt_d = cnt_q + CW'(1);
            else if (do_pop && !do_push)
                cnt_d = cnt_q - CW'(1);
            if (push_i && !do_push)
                ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else if (do_push && !clr_i) begin
            mem_q[wr_q] <= din_i;
        end
    end

    assign valid_o = (cnt_q != '0);
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = full;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/ps2_rx_fifomod.sv
// PS/2 receiver with glitch filter, timeout, E0/F0 decode and event FIFO.
// Parity/stop checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_rx_fifomod
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int DEPTH       = 8,
    parameter int CW          = $clog2(DEPTH) + 1
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          PS2_CLK,
    input  logic          PS2_DAT,
    input  logic          iClear,
    input  logic          iReady,
    output logic          oValid,
    output logic [7:0]    oData,
    output logic          oExt,
    output logic          oBreak,
    output logic [CW-1:0] oCount,
    output logic          oFull,
    output logic          oOvf,
    output logic          oErr
);

    localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          fclk_q;
    logic [FW-1:0] fcnt_q;
    logic          flip, fall;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q;
    logic          frame_ok, frame_bad;

    logic          byte_vld_q;
    logic [7:0]    byte_q;
    logic          ext_q, brk_q, err_q;
    logic          push;
    ps2_evt_t      evt, head;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= PS2_CLK;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= PS2_DAT;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Level flips on the FILTER_LEN-th consecutive opposing sample.
    assign flip = (clk_s2_q != fclk_q) && (fcnt_q == FW'(FILTER_LEN - 1));
    assign fall = flip && fclk_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            fclk_q <= 1'b1;
            fcnt_q <= '0;
        end else if (clk_s2_q == fclk_q) begin
            fcnt_q <= '0;
        end else if (flip) begin
            fclk_q <= clk_s2_q;
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + FW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        par_d     = par_q;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d   = IDLE;
            frame_bad = 1'b1;
        end else if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    sh_d  = {dat_s2_q, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7)
                        state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
`ifdef PS2_PARITY_CHECK_EN
                    if (dat_s2_q && (^{sh_q, par_q}))
                        frame_ok = 1'b1;
                    else
                        frame_bad = 1'b1;
`else
                    frame_ok = 1'b1;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
        end else if (iClear) begin
            state_q <= IDLE;
            bit_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tmo_q   <= (fall || state_q == IDLE) ? '0 : tmo_q + TW'(1);
        end
    end

    assign push = byte_vld_q && (byte_q != PS2_EXT) && (byte_q != PS2_BRK);
    assign evt  = '{ext: ext_q, brk: brk_q, code: byte_q};

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            err_q      <= 1'b0;
        end else if (iClear) begin
            byte_vld_q <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            byte_vld_q <= frame_ok;
            if (frame_ok)
                byte_q <= sh_q;
            if (frame_bad) begin
                err_q <= 1'b1;
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (byte_vld_q) begin
                unique case (1'b1)
                    (byte_q == PS2_EXT): ext_q <= 1'b1;
                    (byte_q == PS2_BRK): brk_q <= 1'b1;
                    default: begin
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    ps2_fifo_basemod #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i   (CLOCK),
        .rst_i   (RESET),
        .clr_i   (iClear),
        .push_i  (push),
        .din_i   (evt),
        .pop_i   (iReady),
        .valid_o (oValid),
        .dout_o  (head),
        .count_o (oCount),
        .full_o  (oFull),
        .ovf_o   (oOvf)
    );

    assign oData  = head.code;
    assign oExt   = head.ext;
    assign oBreak = head.brk;
    assign oErr   = err_q;

endmodule

// File: tb/tb_ps2_rx_fifomod.sv
// Directed scoreboard bench for ps2_rx_fifomod (short filter/timeout settings).
module tb_ps2_rx_fifomod;

    localparam int FL  = 8;
    localparam int TO  = 300;
    localparam int DP  = 8;
    localparam int CW  = $clog2(DP) + 1;
    localparam int HP  = 20;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ps2c = 1'b1;
    logic          ps2d = 1'b1;
    logic          clr = 1'b0;
    logic          rdy = 1'b0;
    logic          oValid, oExt, oBreak, oFull, oOvf, oErr;
    logic [7:0]    oData;
    logic [CW-1:0] oCount;

    int            errs = 0;
    int            checks = 0;
    logic [9:0]    q[$];
    bit            mext = 0, mbrk = 0, merr = 0, movf = 0;

    always #5 clk = ~clk;

    ps2_rx_fifomod #(
        .FILTER_LEN  (FL),
        .TIMEOUT_CYC (TO),
        .DEPTH       (DP)
    ) dut (
        .CLOCK   (clk),
        .RESET   (rst),
        .PS2_CLK (ps2c),
        .PS2_DAT (ps2d),
        .iClear  (clr),
        .iReady  (rdy),
        .oValid  (oValid),
        .oData   (oData),
        .oExt    (oExt),
        .oBreak  (oBreak),
        .oCount  (oCount),
        .oFull   (oFull),
        .oOvf    (oOvf),
        .oErr    (oErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_byte(input logic [7:0] code);
        if (code == 8'hE0) mext = 1;
        else if (code == 8'hF0) mbrk = 1;
        else begin
            if (q.size() == DP) movf = 1;
            else q.push_back({mext, mbrk, code});
            mext = 0;
            mbrk = 0;
        end
    endtask

    task automatic frame(input logic [7:0] code, input bit badpar, input int nbits,
                         input bit lat, input bit popsync, input bit glitch);
        logic [10:0] bits;
        logic        p;
        logic [9:0]  e;
        p = ~^code;
        if (badpar) p = ~p;
        bits = {1'b1, p, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = bits[i];
            if (glitch && i == 4) begin
                cyc(HP / 2);
                ps2c = 1'b0;
                cyc(2);
                ps2c = 1'b1;
                cyc(HP / 2 - 2);
            end else begin
                cyc(HP);
            end
            ps2c = 1'b0;
            for (int j = 1; j <= HP; j++) begin
                @(posedge clk);
                if (i == 10 && lat && j == 10) begin
                    @(negedge clk);
                    chk("lat_pre", oValid, 0);
                end
                if (i == 10 && lat && j == 11) begin
                    @(negedge clk);
                    chk("lat_post", oValid, 1);
                end
                if (i == 10 && popsync && j == 10) begin
                    @(negedge clk);
                    e = q.pop_front();
                    chk("sync_pop", {oExt, oBreak, oData}, e);
                    rdy = 1'b1;
                end
                if (i == 10 && popsync && j == 11) begin
                    #1 rdy = 1'b0;
                end
            end
            #1 ps2c = 1'b1;
        end
        ps2d = 1'b1;
        cyc(HP);
        if (nbits == 11) begin
            if (badpar && PCHK) begin
                mext = 0;
                mbrk = 0;
                merr = 1;
            end else begin
                model_byte(code);
            end
        end
    endtask

    task automatic drain();
        logic [9:0] e;
        for (int k = 0; k < DP + 2; k++) begin
            @(negedge clk);
            if (!oValid) break;
            if (q.size() == 0) begin
                chk("sb_extra", oValid, 0);
                break;
            end
            e = q.pop_front();
            chk("sb_evt", {oExt, oBreak, oData}, e);
            rdy = 1'b1;
            @(posedge clk);
            #1 rdy = 1'b0;
        end
        chk("sb_left", q.size(), 0);
    endtask

    task automatic do_clear();
        @(posedge clk);
        #1 clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        q.delete();
        mext = 0; mbrk = 0; merr = 0; movf = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc(5);
        @(negedge clk);
        chk("rst_valid", oValid, 0);
        chk("rst_data", oData, 0);
        chk("rst_count", oCount, 0);
        chk("rst_flags", {oFull, oOvf, oErr, oExt, oBreak}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(5);

        frame(8'h1C, 0, 11, 1, 0, 0);
        @(negedge clk);
        chk("first_count", oCount, 1);
        drain();

        frame(8'hE0, 0, 11, 0, 0, 0);
        frame(8'hF0, 0, 11, 0, 0, 0);
        frame(8'h75, 0, 11, 0, 0, 0);
        @(negedge clk);
        chk("prefix_count", oCount, 1);
        frame(8'h75, 0, 11, 0, 0, 0);
        drain();

        frame(8'h1C, 1, 11, 0, 0, 0);
        @(negedge clk);
        chk("par_err", oErr, merr);
        chk("par_count", oCount, q.size());
        drain();
        do_clear();
        @(negedge clk);
        chk("clr_err", oErr, 0);

        frame(8'h55, 0, 5, 0, 0, 0);
        cyc(TO + 100);
        mext = 0; mbrk = 0; merr = 1;
        @(negedge clk);
        chk("tmo_err", oErr, 1);
        chk("tmo_count", oCount, 0);
        frame(8'h29, 0, 11, 0, 0, 0);
        drain();
        do_clear();

        for (int n = 1; n <= DP + 1; n++)
            frame(8'(n), 0, 11, 0, 0, 0);
        @(negedge clk);
        chk("ovf_count", oCount, DP);
        chk("ovf_full", oFull, 1);
        chk("ovf_flag", oOvf, movf);
        drain();
        do_clear();
        @(negedge clk);
        chk("clr_ovf", oOvf, 0);
        for (int n = 0; n < DP; n++)
            frame(8'h30 + 8'(n), 0, 11, 0, 0, 0);
        frame(8'h4A, 0, 11, 0, 1, 0);
        @(negedge clk);
        chk("sync_count", oCount, DP);
        chk("sync_ovf", oOvf, 0);
        drain();

        frame(8'h5A, 0, 11, 0, 0, 1);
        @(negedge clk);
        chk("glitch_count", oCount, 1);
        drain();

        frame(8'h44, 0, 11, 0, 0, 0);
        frame(8'h33, 0, 6, 0, 0, 0);
        @(negedge clk);
        chk("pre_rst_valid", oValid, 1);
        #1 rst = 1'b1;
        #2;
        chk("mid_rst_valid", oValid, 0);
        chk("mid_rst_count", oCount, 0);
        chk("mid_rst_out", {oData, oExt, oBreak, oFull, oOvf, oErr}, 0);
        q.delete();
        mext = 0; mbrk = 0; merr = 0; movf = 0;
        cyc(3);
        rst = 1'b0;
        cyc(5);
        frame(8'h12, 0, 11, 0, 0, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifomod.md
Name: ps2_rx_fifomod

Overview:
Parametrised successor to the single-byte PS/2 receiver. Recovers PS/2 device frames with a glitch filter, parity/stop check and inactivity timeout. Decodes E0/F0 prefixes into extended/break flags and buffers decoded key events in a first-word-fall-through FIFO with a valid/ready read port. Sits between the PS2_CLK/PS2_DAT pins and consumers such as the display path or a key-handling controller.

Parameters:
FILTER_LEN, 8, consecutive identical samples required before filtered PS2_CLK changes level (>=2).
TIMEOUT_CYC, 100000, CLOCK cycles without a PS2_CLK falling edge before a partial frame is aborted (2 ms at 50 MHz).
DEPTH, 8, FIFO entries; power of two, >=2.
CW, $clog2(DEPTH)+1, width of oCount (derived; do not override).

Ports:
CLOCK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
PS2_CLK  in  1  raw PS/2 clock pin
PS2_DAT  in  1  raw PS/2 data pin
iClear  in  1  synchronous flush: FIFO, prefix flags, sticky flags, FSM to IDLE
iReady  in  1  consumer accepts head entry when oValid=1
oValid  out  1  FIFO non-empty; head entry present on oData/oExt/oBreak
oData  out  8  scan code of head entry
oExt  out  1  head entry was prefixed by E0
oBreak  out  1  head entry was prefixed by F0 (key release)
oCount  out  CW  entries held, 0..DEPTH
oFull  out  1  oCount==DEPTH
oOvf  out  1  sticky: event dropped because FIFO full
oErr  out  1  sticky: frame discarded (parity, stop bit or timeout)

Behaviour:
- Reset (RESET=1, asynchronous): all outputs 0, FSM IDLE, sync/filter registers 1, FIFO empty, prefix flags 0, timeout counter 0.
- Input path: PS2_CLK and PS2_DAT each pass a 2-flop synchroniser. Filtered clock toggles only after FILTER_LEN consecutive samples opposing its current level. One-cycle fall pulse on filtered 1->0. PS2_DAT is sampled (synchronised) on the fall pulse cycle.
- Frame FSM, advances only on fall pulse:
  - IDLE: DAT=0 -> DATA, bit count 0. DAT=1 -> stay (spurious edge ignored).
  - DATA: shift DAT in LSB first; after 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: frame good if stop=1 and XOR(data,parity)=1 (odd parity). Good -> byte to decoder. Bad -> set oErr, clear prefix flags. Always -> IDLE.
- Timeout: counter clears on every fall pulse and in IDLE. In any other state, reaching TIMEOUT_CYC-1 -> IDLE, frame discarded, oErr set, prefix flags cleared.
- Decoder, one cycle after STOP acceptance:
  - E0: set ext flag, no push.
  - F0: set brk flag, no push.
  - Any other byte, including E1: push {ext,brk,byte}, then clear both flags.
  - Repeated prefixes are idempotent.
- Latency: stop-bit fall pulse at cycle t -> FIFO write at t+1 -> oValid=1 with entry at t+2.
- FIFO, FWFT: pop when oValid&iReady. Push while full -> entry dropped, oOvf set. Push and pop in the same cycle when full -> both occur, count unchanged, no overflow. Push into empty FIFO is not visible the same cycle. Read/write pointers wrap modulo DEPTH.
- oData/oExt/oBreak hold the last value while oValid=0 and must not be relied on.
- iClear has priority over push/pop in its cycle. oErr/oOvf clear only on reset or iClear.

Optional Feature:
PS2_PARITY_CHECK_EN.
- Defined: parity and stop bit checked as above.
- Undefined: parity and stop bits are ignored; every completed frame is accepted. Timeouts still set oErr.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0;
  - state enum {IDLE,DATA,PARITY,STOP};
  - packed struct ps2_evt_t {ext,brk,code[7:0]}.
- One sub-module: ps2_fifo_basemod, a generic FWFT FIFO of ps2_evt_t with DEPTH, count, full and overflow outputs.
- Synchroniser, filter, FSM and decoder stay in the top.

Test Plan:
- Send frame 0x1C (parity 0, stop 1), FILTER_LEN=8 -> oValid rises 2 cycles after last fall pulse; oData=0x1C, oExt=0, oBreak=0, oCount=1.
- Send E0,F0,0x75 -> exactly one entry {ext=1,brk=1,0x75}. Next 0x75 -> {0,0,0x75}.
- Send 0x1C with parity 1 -> no entry, oErr=1. With PS2_PARITY_CHECK_EN undefined -> entry 0x1C, oErr=0.
- Stop PS2_CLK after 4 data bits for TIMEOUT_CYC cycles -> FSM IDLE, oErr=1. Following good frame 0x29 -> entry 0x29.
- DEPTH=8, iReady=0, send 9 codes -> oCount=8, oFull=1, oOvf=1, first 8 read back in order. Push with iReady=1 while full -> oCount stays 8, no new overflow.
- 2-cycle glitch on PS2_CLK mid-frame -> no bit shifted. Assert RESET mid-frame -> all outputs 0 immediately. Next full frame decodes correctly.
